// File: rtl/hud_lives_tracker.sv
// ============================================================================
// Module   : hud_lives_tracker
// Purpose  : Life counter with post-hit blink FSM and heart-row pixel decode
//            feeding the HUD heart bitmap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hud_lives_tracker #(
    parameter int unsigned MAX_LIVES     = 5,
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned TOP_LEFT_X    = 16,
    parameter int unsigned TOP_LEFT_Y    = 8,
    parameter int unsigned HEART_SIZE    = 32,
    parameter int unsigned HEART_SPACING = 36,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        hit,
    input  logic        bonus,
    input  logic        restart,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [2:0]  lives,
    output logic        gameOver
);

    localparam int unsigned INVULN_W = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [10:0] Y_TOP    = 11'(TOP_LEFT_Y);
    localparam logic [10:0] Y_BOT    = 11'(TOP_LEFT_Y + HEART_SIZE);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_INVULN    = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            lives_q, lives_d;
    logic [INVULN_W-1:0]   invuln_cnt_q, invuln_cnt_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_on_q, blink_on_d;
    logic                  game_over_q;
    logic [10:0]           offx_q, offx_d;
    logic [10:0]           offy_q, offy_d;
    logic                  inside_q, inside_d;
    logic [2:0]            lives_plus;

    assign lives_plus = (lives_q == 3'(MAX_LIVES)) ? lives_q : lives_q + 3'd1;

    // ------------------------------------------------------------------
    // Life / invulnerability state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        invuln_cnt_d = invuln_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;

        if (restart) begin
            state_d      = ST_ALIVE;
            lives_d      = 3'(INIT_LIVES);
            invuln_cnt_d = '0;
            blink_cnt_d  = '0;
            blink_on_d   = 1'b1;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    // Simultaneous hit and bonus cancel each other out
                    if (hit && !bonus) begin
                        if (lives_q > 3'd1) begin
                            lives_d      = lives_q - 3'd1;
                            state_d      = ST_INVULN;
                            invuln_cnt_d = INVULN_W'(INVULN_FRAMES);
                            blink_cnt_d  = '0;
                            blink_on_d   = 1'b1;
                        end else begin
                            lives_d = 3'd0;
                            state_d = ST_GAME_OVER;
                        end
                    end else if (bonus && !hit) begin
                        lives_d = lives_plus;
                    end
                end
                ST_INVULN: begin
                    if (bonus) begin
                        lives_d = lives_plus;
                    end
                    if (startOfFrame) begin
                        if (invuln_cnt_q == INVULN_W'(1)) begin
                            state_d      = ST_ALIVE;
                            invuln_cnt_d = '0;
                            blink_cnt_d  = '0;
                            blink_on_d   = 1'b1;
                        end else begin
                            invuln_cnt_d = invuln_cnt_q - INVULN_W'(1);
                            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                                blink_cnt_d = '0;
                                blink_on_d  = ~blink_on_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_GAME_OVER;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Heart-slot decode: one parallel compare per slot
    // ------------------------------------------------------------------
    logic [MAX_LIVES-1:0] slot_sel;
    logic [10:0]          slot_offx [MAX_LIVES];
    logic                 in_y;

    assign in_y = (pixelY >= Y_TOP) && (pixelY < Y_BOT);

    generate
        for (genvar k = 0; k < MAX_LIVES; k++) begin : g_slot
            localparam logic [10:0] LEFT  = 11'(TOP_LEFT_X + k * HEART_SPACING);
            localparam logic [10:0] RIGHT = 11'(TOP_LEFT_X + k * HEART_SPACING + HEART_SIZE);
            logic in_x;
            logic drawn;
            assign in_x  = (pixelX >= LEFT) && (pixelX < RIGHT);
            assign drawn = (32'(lives_q) > 32'(k)) ||
                           ((state_q == ST_INVULN) && (32'(lives_q) == 32'(k)) && blink_on_q);
            assign slot_sel[k]  = in_x && in_y && drawn;
            assign slot_offx[k] = pixelX - LEFT;
        end
    endgenerate

    always_comb begin
        offx_d   = '0;
        inside_d = |slot_sel;
        for (int i = 0; i < MAX_LIVES; i++) begin
            if (slot_sel[i]) begin
                offx_d = slot_offx[i];
            end
        end
        offy_d = inside_d ? (pixelY - Y_TOP) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ALIVE;
            lives_q      <= 3'(INIT_LIVES);
            invuln_cnt_q <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            game_over_q  <= 1'b0;
            offx_q       <= '0;
            offy_q       <= '0;
            inside_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            invuln_cnt_q <= invuln_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            game_over_q  <= (state_d == ST_GAME_OVER);
            offx_q       <= offx_d;
            offy_q       <= offy_d;
            inside_q     <= inside_d;
        end
    end

    assign offsetX         = offx_q;
    assign offsetY         = offy_q;
    assign InsideRectangle = inside_q;
    assign lives           = lives_q;
    assign gameOver        = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_hud_lives_tracker.sv
// ============================================================================
// Module   : tb_hud_lives_tracker
// Purpose  : Directed self-checking bench for hud_lives_tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hud_lives_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        hit = 1'b0;
    logic        bonus = 1'b0;
    logic        restart = 1'b0;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic [2:0]  lives;
    logic        gameOver;

    int checks = 0;
    int errors = 0;

    hud_lives_tracker dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .hit             (hit),
        .bonus           (bonus),
        .restart         (restart),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .lives           (lives),
        .gameOver        (gameOver)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic probe(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick();
    endtask

    task automatic pulse(input logic h, input logic b, input logic r);
        hit = h; bonus = b; restart = r;
        tick();
        hit = 1'b0; bonus = 1'b0; restart = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int xs [8] = '{16, 48, 88, 124, 160, 47, 16, 15};
        int ys [8] = '{8,  8,  39, 39,  8,   39, 40, 8};
        logic       ei [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int exs [8] = '{0, 0, 0, 0, 0, 31, 0, 0};
        int eys [8] = '{0, 0, 31, 0, 0, 31, 0, 0};
        checks++;
        if (lives !== 3'd3 || gameOver !== 1'b0 || InsideRectangle !== 1'b0 ||
            offsetX !== 11'd0 || offsetY !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: lives=%0d go=%b in=%b off=(%0d,%0d) expected 3 0 0 (0,0)",
                     lives, gameOver, InsideRectangle, offsetX, offsetY);
        end
        for (int i = 0; i < 8; i++) begin
            probe(xs[i], ys[i]);
            checks++;
            if (InsideRectangle !== ei[i] || offsetX !== 11'(exs[i]) || offsetY !== 11'(eys[i])) begin
                errors++;
                $display("FAIL pixel(%0d,%0d): in=%b off=(%0d,%0d) expected in=%b off=(%0d,%0d)",
                         xs[i], ys[i], InsideRectangle, offsetX, offsetY, ei[i], exs[i], eys[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic exp_vis;
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (lives !== 3'd2 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL hit_alive: lives=%0d go=%b expected 2 0", lives, gameOver);
        end
        probe(88, 8);
        checks++;
        if (InsideRectangle !== 1'b1) begin
            errors++;
            $display("FAIL blink_f0: in=%b expected 1", InsideRectangle);
        end
        for (int f = 1; f <= 60; f++) begin
            frame();
            probe(88, 8);
            exp_vis = (f < 60) && (((f / 4) % 2) == 0);
            checks++;
            if (InsideRectangle !== exp_vis) begin
                errors++;
                $display("FAIL blink_f%0d: in=%b expected %b", f, InsideRectangle, exp_vis);
            end
        end
        for (int f = 0; f < 8; f++) begin
            frame();
            probe(88, 8);
            checks++;
            if (InsideRectangle !== 1'b0) begin
                errors++;
                $display("FAIL after_invuln_f%0d: in=%b expected 0", f, InsideRectangle);
            end
        end
        probe(52, 8);
        checks++;
        if (InsideRectangle !== 1'b1 || offsetX !== 11'd0) begin
            errors++;
            $display("FAIL slot1_visible: in=%b offx=%0d expected 1 0", InsideRectangle, offsetX);
        end
    endtask

    task automatic test_game_over();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (lives !== 3'd2) begin
            errors++;
            $display("FAIL hit_in_invuln: lives=%0d expected 2", lives);
        end
        for (int f = 0; f < 60; f++) frame();
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (lives !== 3'd1 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL hit_to_one: lives=%0d go=%b expected 1 0", lives, gameOver);
        end
        for (int f = 0; f < 60; f++) frame();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++;
        if (lives !== 3'd0 || gameOver !== 1'b1) begin
            errors++;
            $display("FAIL fatal_hit: lives=%0d go=%b expected 0 1", lives, gameOver);
        end
        pulse(1'b0, 1'b1, 1'b0);
        probe(16, 8);
        checks++;
        if (lives !== 3'd0 || gameOver !== 1'b1 || InsideRectangle !== 1'b0) begin
            errors++;
            $display("FAIL bonus_in_gameover: lives=%0d go=%b in=%b expected 0 1 0",
                     lives, gameOver, InsideRectangle);
        end
    endtask

    task automatic test_bonus();
        int exp_l [3] = '{4, 5, 5};
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (lives !== 3'd3 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_gameover: lives=%0d go=%b expected 3 0", lives, gameOver);
        end
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            checks++;
            if (lives !== 3'(exp_l[i])) begin
                errors++;
                $display("FAIL bonus_%0d: lives=%0d expected %0d", i, lives, exp_l[i]);
            end
        end
        pulse(1'b1, 1'b1, 1'b0);
        probe(160, 8);
        checks++;
        if (lives !== 3'd5 || InsideRectangle !== 1'b1 || offsetX !== 11'd0) begin
            errors++;
            $display("FAIL hit_bonus_cancel: lives=%0d in=%b offx=%0d expected 5 1 0",
                     lives, InsideRectangle, offsetX);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (lives !== 3'd4) begin
            errors++;
            $display("FAIL still_alive_after_cancel: lives=%0d expected 4", lives);
        end
    endtask

    task automatic test_restart();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 30; f++) frame();
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (lives !== 3'd3 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL restart_invuln: lives=%0d go=%b expected 3 0", lives, gameOver);
        end
        for (int f = 0; f < 6; f++) begin
            frame();
            probe(124, 8);
            checks++;
            if (InsideRectangle !== 1'b0) begin
                errors++;
                $display("FAIL no_blink_after_restart_f%0d: in=%b expected 0", f, InsideRectangle);
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        checks++;
        if (lives !== 3'd3 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL restart_plus_hit: lives=%0d go=%b expected 3 0", lives, gameOver);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (lives !== 3'd2) begin
            errors++;
            $display("FAIL alive_after_restart_hit: lives=%0d expected 2", lives);
        end
    endtask

    task automatic test_async_reset();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        probe(30, 20);
        checks++;
        if (InsideRectangle !== 1'b1 || offsetX !== 11'd14 || offsetY !== 11'd12 || lives !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_scan: in=%b off=(%0d,%0d) lives=%0d expected 1 (14,12) 2",
                     InsideRectangle, offsetX, offsetY, lives);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (InsideRectangle !== 1'b0 || offsetX !== 11'd0 || offsetY !== 11'd0 ||
            lives !== 3'd3 || gameOver !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: in=%b off=(%0d,%0d) lives=%0d go=%b expected 0 (0,0) 3 0",
                     InsideRectangle, offsetX, offsetY, lives, gameOver);
        end
        tick();
        #2;
        reset = 1'b0;
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (lives !== 3'd2) begin
            errors++;
            $display("FAIL alive_after_reset: lives=%0d expected 2", lives);
        end
    endtask

    initial begin
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        test_reset();
        test_blink();
        test_game_over();
        test_bonus();
        test_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
